// File: rtl/fifo_pkt_reader.sv
// Read-side drainer for the synchronous FIFO: strips header words and emits the payload as a
// valid/ready stream with tlast, using a 2-entry skid buffer to cover read latency and flag lag.
module fifo_pkt_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_empty,
  input  logic                  i_aempty,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_tvalid,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  input  logic                  i_tready,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
  output logic                  o_idle
);

  typedef enum logic [0:0] {StHdr, StPay} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                 pop, push, push_last, throttled;
  logic [2:0]           credit;
  logic [LEN_WIDTH-1:0] hdr_len;

  assign hdr_len   = i_rd_data[LEN_WIDTH-1:0];
  assign pop       = o_tvalid && i_tready;
  assign push      = inflight_q && (state_q == StPay);
  assign push_last = (rem_q == LEN_WIDTH'(1));

  // Reserve a buffer slot for every read in flight, headers included.
  assign credit    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Flags are one cycle stale after a read; near empty wait one cycle before trusting them.
  assign throttled = i_aempty && inflight_q;
  assign o_rd_en   = i_rst_n && !i_empty && (credit < 3'd2) && !throttled;

  assign o_tvalid  = (occ_q != 2'd0);
  assign o_tdata   = head_data_q;
  assign o_tlast   = head_last_q;
  assign o_pkt_cnt = cnt_q;
  assign o_idle    = !inflight_q && (occ_q == 2'd0) && (state_q == StHdr);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (inflight_q) begin
      unique case (state_q)
        StHdr: begin
          if (hdr_len != '0) begin
            rem_d   = hdr_len;
            state_d = StPay;
          end
        end
        StPay: begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (push_last) state_d = StHdr;
        end
        default: state_d = StHdr;
      endcase
    end
  end

  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_data_d = i_rd_data;
          head_last_d = push_last;
        end else begin
          tail_data_d = i_rd_data;
          tail_last_d = push_last;
        end
      end
      2'b01: begin
        occ_d       = occ_q - 2'd1;
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_data_d = i_rd_data;
          head_last_d = push_last;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = i_rd_data;
          tail_last_d = push_last;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop && head_last_q) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StHdr;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      inflight_q  <= o_rd_en;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
